// File: rtl/otter_li_encoder_pkg.sv
// Shared definitions for the load-immediate encoder and the immediate packer.
// Holds the opcode/funct3/NOP constants, the IMM_GEN_SEL_* encodings shared with
// the core's immediate generator, FSM state type and the request plan helper.
// Configuration macro: OTTER_LI_COMPRESS_EN (defined = drop redundant LUI/ADDI).
package otter_li_encoder_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned HI_W  = 20;
    localparam int unsigned LO_W  = 12;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [2:0] FUNCT3_ADDI   = 3'b000;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

    localparam logic [2:0] IMM_GEN_SEL_I = 3'd0;
    localparam logic [2:0] IMM_GEN_SEL_S = 3'd1;
    localparam logic [2:0] IMM_GEN_SEL_B = 3'd2;
    localparam logic [2:0] IMM_GEN_SEL_U = 3'd3;
    localparam logic [2:0] IMM_GEN_SEL_J = 3'd4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_LUI  = 2'd1,
        EMIT_ADDI = 2'd2
    } li_state_e;

    // Everything latched on accept that the emit states need.
    typedef struct packed {
        li_state_e        first_state;
        logic [REG_W-1:0] rd;
        logic [HI_W-1:0]  hi;
        logic [LO_W-1:0]  lo;
        logic             addi_follows;
        logic             rs1_is_rd;
    } li_plan_t;

    // Split the constant and choose the instruction sequence.
    function automatic li_plan_t li_make_plan(input logic [REG_W-1:0] rd,
                                              input logic [XLEN-1:0]  value);
        li_plan_t p;
        // (value + 0x800)[31:12]: the low bits only contribute a carry via bit 11.
        p.hi           = value[31:12] + HI_W'(value[11]);
        p.lo           = value[11:0];
        p.rd           = rd;
        p.first_state  = EMIT_LUI;
        p.addi_follows = 1'b1;
        p.rs1_is_rd    = 1'b1;
        if (rd == '0) begin
            // ADDI x0,x0,0 is the canonical NOP.
            p.hi           = '0;
            p.lo           = '0;
            p.first_state  = EMIT_ADDI;
            p.addi_follows = 1'b0;
            p.rs1_is_rd    = 1'b0;
        end
`ifdef OTTER_LI_COMPRESS_EN
        else if (p.hi == '0) begin
            p.first_state  = EMIT_ADDI;
            p.addi_follows = 1'b0;
            p.rs1_is_rd    = 1'b0;
        end else if (p.lo == '0) begin
            p.addi_follows = 1'b0;
        end
`endif
        return p;
    endfunction

endpackage

// File: rtl/otter_imm_pack.sv
// Combinational inverse of the immediate generator: inserts the immediate
// bitfields selected by sel_i into base_i (base immediate fields expected zero).
// Ports: imm_i (32-bit immediate), sel_i (IMM_GEN_SEL_*), base_i (instruction
// without immediate), instr_o (instruction with immediate inserted).
module otter_imm_pack
    import otter_li_encoder_pkg::*;
(
    input  logic [XLEN-1:0] imm_i,
    input  logic [2:0]      sel_i,
    input  logic [XLEN-1:0] base_i,
    output logic [XLEN-1:0] instr_o
);

    always_comb begin
        instr_o = base_i;
        case (sel_i)
            IMM_GEN_SEL_I: instr_o[31:20] = imm_i[11:0];
            IMM_GEN_SEL_S: begin
                instr_o[31:25] = imm_i[11:5];
                instr_o[11:7]  = imm_i[4:0];
            end
            IMM_GEN_SEL_B: begin
                instr_o[31]    = imm_i[12];
                instr_o[30:25] = imm_i[10:5];
                instr_o[11:8]  = imm_i[4:1];
                instr_o[7]     = imm_i[11];
            end
            IMM_GEN_SEL_U: instr_o[31:12] = imm_i[31:12];
            IMM_GEN_SEL_J: begin
                instr_o[31]    = imm_i[20];
                instr_o[30:21] = imm_i[10:1];
                instr_o[20]    = imm_i[11];
                instr_o[19:12] = imm_i[19:12];
            end
            default: instr_o = base_i;
        endcase
    end

endmodule

// File: rtl/otter_li_encoder.sv
// Load-immediate encoder: turns (rd, 32-bit constant) into the LUI/ADDI sequence
// that materialises the constant in rd, for injection ahead of the fetch mux.
// Ports: i_clk/i_rst (sync active-high reset); request side i_req_valid,
// o_req_ready, i_req_rd, i_req_value; instruction side o_ins_valid, i_ins_ready,
// o_ins_instrn, o_ins_last (all instruction outputs registered).
// Configuration macro: OTTER_LI_COMPRESS_EN (handled in li_make_plan).
module otter_li_encoder
    import otter_li_encoder_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [REG_W-1:0] i_req_rd,
    input  logic [XLEN-1:0]  i_req_value,
    output logic             o_ins_valid,
    input  logic             i_ins_ready,
    output logic [XLEN-1:0]  o_ins_instrn,
    output logic             o_ins_last
);

    li_state_e       state_q, state_d;
    li_plan_t        plan_q, plan_d;
    logic            ins_valid_q, ins_valid_d;
    logic [XLEN-1:0] instrn_q, instrn_d;
    logic            last_q, last_d;
    logic [XLEN-1:0] lui_instr, addi_instr;
    logic [REG_W-1:0] rs1_d;
    logic            accept;

    // Ready only in IDLE and never while reset is asserted.
    assign o_req_ready = (state_q == IDLE) && !i_rst;
    assign accept      = i_req_valid && o_req_ready;

    // Next-state and plan latch.
    always_comb begin
        state_d = state_q;
        plan_d  = plan_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    plan_d  = li_make_plan(i_req_rd, i_req_value);
                    state_d = plan_d.first_state;
                end
            end
            EMIT_LUI: begin
                if (i_ins_ready) state_d = plan_q.addi_follows ? EMIT_ADDI : IDLE;
            end
            EMIT_ADDI: begin
                if (i_ins_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rs1_d = plan_d.rs1_is_rd ? plan_d.rd : '0;

    otter_imm_pack u_pack_lui (
        .imm_i   ({plan_d.hi, 12'b0}),
        .sel_i   (IMM_GEN_SEL_U),
        .base_i  ({20'b0, plan_d.rd, OPCODE_LUI}),
        .instr_o (lui_instr)
    );

    otter_imm_pack u_pack_addi (
        .imm_i   ({{(XLEN-LO_W){plan_d.lo[LO_W-1]}}, plan_d.lo}),
        .sel_i   (IMM_GEN_SEL_I),
        .base_i  ({12'b0, rs1_d, FUNCT3_ADDI, plan_d.rd, OPCODE_OP_IMM}),
        .instr_o (addi_instr)
    );

    // Outputs are a function of the next state, so they register alongside it
    // and stay constant while the current instruction is stalled.
    always_comb begin
        ins_valid_d = 1'b0;
        instrn_d    = '0;
        last_d      = 1'b0;
        case (state_d)
            EMIT_LUI: begin
                ins_valid_d = 1'b1;
                instrn_d    = lui_instr;
                last_d      = !plan_d.addi_follows;
            end
            EMIT_ADDI: begin
                ins_valid_d = 1'b1;
                instrn_d    = (plan_d.rd == '0) ? NOP : addi_instr;
                last_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            plan_q      <= '0;
            ins_valid_q <= 1'b0;
            instrn_q    <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            plan_q      <= plan_d;
            ins_valid_q <= ins_valid_d;
            instrn_q    <= instrn_d;
            last_q      <= last_d;
        end
    end

    assign o_ins_valid  = ins_valid_q;
    assign o_ins_instrn = instrn_q;
    assign o_ins_last   = last_q;

endmodule

// File: tb/tb_otter_li_encoder.sv
// Directed and randomised bench for otter_li_encoder. Expectations follow the
// build: define OTTER_LI_COMPRESS_EN for both RTL and bench to test compression.
module tb_otter_li_encoder;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [4:0]  i_req_rd;
    logic [31:0] i_req_value;
    logic        o_ins_valid;
    logic        i_ins_ready;
    logic [31:0] o_ins_instrn;
    logic        o_ins_last;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    otter_li_encoder dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_rd     (i_req_rd),
        .i_req_value  (i_req_value),
        .o_ins_valid  (o_ins_valid),
        .i_ins_ready  (i_ins_ready),
        .o_ins_instrn (o_ins_instrn),
        .o_ins_last   (o_ins_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] rd, input logic [31:0] v);
        int n = 0;
        while (!o_req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        i_req_rd    = rd;
        i_req_value = v;
        step();
        i_req_valid = 1'b0;
        i_req_rd    = 5'($urandom);
        i_req_value = $urandom;
    endtask

    task automatic take(output logic [31:0] ins, output logic last, output int waited);
        waited      = 0;
        i_ins_ready = 1'b1;
        while (!o_ins_valid && waited < 20) begin
            step();
            waited++;
        end
        chk("take_valid", 32'(o_ins_valid), 32'd1);
        ins  = o_ins_instrn;
        last = o_ins_last;
        step();
    endtask

    task automatic expect_seq(input string tag, input logic [4:0] rd, input logic [31:0] v,
                              input int n, input logic [31:0] e0, input logic [31:0] e1);
        logic [31:0] ins;
        logic        last;
        int          w;
        send(rd, v);
        chk({tag, "_latency"}, 32'(o_ins_valid), 32'd1);
        take(ins, last, w);
        chk({tag, "_ins0"}, ins, e0);
        chk({tag, "_last0"}, 32'(last), 32'(n == 1));
        if (n == 2) begin
            take(ins, last, w);
            chk({tag, "_nobubble"}, 32'(w), 32'd0);
            chk({tag, "_ins1"}, ins, e1);
            chk({tag, "_last1"}, 32'(last), 32'd1);
        end
        chk({tag, "_ready_after"}, 32'(o_req_ready), 32'd1);
        chk({tag, "_idle_after"}, 32'(o_ins_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        logic        last;
        int          w;
        logic [31:0] rf [32];
        logic [4:0]  rrd;
        logic [31:0] rv;
        logic [31:0] val;

        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_rd    = '0;
        i_req_value = '0;
        i_ins_ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_valid", 32'(o_ins_valid), 32'd0);
        chk("rst_instrn", o_ins_instrn, 32'h0);
        chk("rst_last", 32'(o_ins_last), 32'd0);
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        i_rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(o_req_ready), 32'd1);

        // Sequences common to both configurations
        expect_seq("full", 5'd5, 32'h1234_5678, 2, 32'h1234_52B7, 32'h6782_8293);
        expect_seq("round", 5'd1, 32'h0000_0800, 2, 32'h0000_10B7, 32'h8000_8093);
        expect_seq("nop", 5'd0, 32'hDEAD_BEEF, 1, 32'h0000_0013, 32'h0);

`ifdef OTTER_LI_COMPRESS_EN
        expect_seq("neg", 5'd1, 32'hFFFF_F800, 1, 32'h8000_0093, 32'h0);
        expect_seq("lui_only", 5'd1, 32'h0000_1000, 1, 32'h0000_10B7, 32'h0);
        expect_seq("zero", 5'd1, 32'h0000_0000, 1, 32'h0000_0093, 32'h0);
        expect_seq("ones", 5'd31, 32'hFFFF_FFFF, 1, 32'hFFF0_0F93, 32'h0);
`else
        expect_seq("neg", 5'd1, 32'hFFFF_F800, 2, 32'h0000_00B7, 32'h8000_8093);
        expect_seq("lui_only", 5'd1, 32'h0000_1000, 2, 32'h0000_10B7, 32'h0000_8093);
        expect_seq("zero", 5'd1, 32'h0000_0000, 2, 32'h0000_00B7, 32'h0000_8093);
        expect_seq("ones", 5'd31, 32'hFFFF_FFFF, 2, 32'h0000_0FB7, 32'hFFFF_8F93);
`endif

        // Backpressure with a competing request that must be ignored
        send(5'd5, 32'h1234_5678);
        i_ins_ready = 1'b0;
        i_req_valid = 1'b1;
        i_req_rd    = 5'd7;
        i_req_value = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(o_ins_valid), 32'd1);
            chk("bp_instrn", o_ins_instrn, 32'h1234_52B7);
            chk("bp_last", 32'(o_ins_last), 32'd0);
            chk("bp_req_ready", 32'(o_req_ready), 32'd0);
            step();
        end
        i_req_valid = 1'b0;
        take(ins, last, w);
        chk("bp_ins0", ins, 32'h1234_52B7);
        take(ins, last, w);
        chk("bp_ins1", ins, 32'h6782_8293);
        chk("bp_last1", 32'(last), 32'd1);
        chk("bp_no_extra", 32'(o_ins_valid), 32'd0);

        // Reset mid-sequence
        send(5'd9, 32'h1234_5678);
        take(ins, last, w);
        chk("mid_rst_ins0", ins, 32'h1234_54B7);
        i_ins_ready = 1'b0;
        i_rst       = 1'b1;
        step();
        chk("mid_rst_valid", 32'(o_ins_valid), 32'd0);
        chk("mid_rst_ready", 32'(o_req_ready), 32'd0);
        i_rst = 1'b0;
        step();
        chk("mid_rst_ready_after", 32'(o_req_ready), 32'd1);
        expect_seq("after_rst", 5'd1, 32'h0000_0800, 2, 32'h0000_10B7, 32'h8000_8093);

        // Random: execute the emitted instructions and compare the register
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        for (int t = 0; t < 1000; t++) begin
            rrd = 5'($urandom_range(0, 31));
            case (t % 8)
                0:       rv = 32'h0;
                1:       rv = {$urandom} | 32'h0000_0800;
                2:       rv = {20'($urandom), 12'h0};
                default: rv = $urandom;
            endcase
            if (rrd != 5'd0) rf[rrd] = $urandom;
            send(rrd, rv);
            for (int k = 0; k < 3; k++) begin
                take(ins, last, w);
                val = 32'hxxxx_xxxx;
                if (ins[6:0] == 7'b0110111)
                    val = {ins[31:12], 12'h0};
                else if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'b000)
                    val = rf[ins[19:15]] + {{20{ins[31]}}, ins[31:20]};
                if (ins[11:7] != 5'd0) rf[ins[11:7]] = val;
                if (last) break;
            end
            chk("rand_reg", rf[rrd], (rrd == 5'd0) ? 32'h0 : rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
